// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract sequencer.
// Latches two operands and feeds an external 1-bit full adder one bit per
// clock, LSB first. It collects the sum bits, the final carry (or no-borrow)
// and the signed overflow flag.
module serial_add_sequencer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_s,
  input  logic             fa_co,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic             msb_cin;
  logic [IDX_W-1:0] idx;

  // State register; reset has priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture in IDLE and bit-serial result assembly in SHIFT.
  // Subtraction is A + ~B + 1, so B is inverted and the carry is seeded with 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      msb_cin   <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a_in;
            b_reg     <= op_sub ? ~b_in : b_in;
            carry_reg <= op_sub;
            idx       <= '0;
          end
        end
        SHIFT: begin
          result[idx] <= fa_s;
          carry_reg   <= fa_co;
          if (idx == LAST_IDX) begin
            msb_cin   <= carry_reg;
            carry_out <= fa_co;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Overflow is the carry into the MSB XOR the carry out of the MSB. Both
  // terms are captured on the final SHIFT edge and held until the next
  // operation, so the flag has the same timing as a registered copy.
  assign overflow = msb_cin ^ carry_out;

  // Next-state logic and adder drive. The adder inputs come from
  // registers only, so no input reaches an output combinationally.
  always_comb begin
    state_next = state;
    fa_a       = 1'b0;
    fa_b       = 1'b0;
    fa_c       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        fa_a = a_reg[idx];
        fa_b = b_reg[idx];
        fa_c = carry_reg;
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard testbench for serial_add_sequencer (WIDTH=3).
// The bench models the external full adder. Stimulus pushes the expected
// results, and a monitor pops and compares them on every done pulse.
module tb_serial_add_sequencer;

  localparam int W = 3;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         fa_a;
  logic         fa_b;
  logic         fa_c;
  logic         fa_s;
  logic         fa_co;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int cycle = 0;
  int last_done_cycle = 0;
  int prev_done_cycle = 0;

  // Expected {result, carry_out, overflow} per accepted operation
  logic [W+1:0] exp_q[$];

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op_sub    (op_sub),
    .a_in      (a_in),
    .b_in      (b_in),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_c      (fa_c),
    .fa_s      (fa_s),
    .fa_co     (fa_co),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  // Reference 1-bit full adder stage
  assign fa_s  = fa_a ^ fa_b ^ fa_c;
  assign fa_co = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, used to measure back-to-back spacing
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Present one request for a single cycle; returns at the negedge after the
  // accepting edge, i.e. during the first SHIFT cycle.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, input logic expect_done,
                               input logic [W+1:0] expected);
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    op_sub = sub;
    start  = 1'b1;
    if (expect_done) exp_q.push_back(expected);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Check adder drive over all SHIFT cycles; bit i of each vector is cycle i
  task automatic checkSequence(input string tag, input logic [W-1:0] ea,
                               input logic [W-1:0] eb, input logic [W-1:0] ec);
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput($sformatf("%s_fa_a[%0d]", tag, i), 32'(fa_a), 32'(ea[i]));
      checkOutput($sformatf("%s_fa_b[%0d]", tag, i), 32'(fa_b), 32'(eb[i]));
      checkOutput($sformatf("%s_fa_c[%0d]", tag, i), 32'(fa_c), 32'(ec[i]));
    end
  endtask

  // Bounded wait until the sequencer returns to IDLE
  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: busy still %0b after %0d cycles", tag, busy, n);
    end
  endtask

  // Monitor: every done pulse is matched against the scoreboard head
  always @(negedge clk) begin : monitor
    logic [W+1:0] e;
    if (!reset && done) begin
      done_count++;
      prev_done_cycle = last_done_cycle;
      last_done_cycle = cycle;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_result", 32'(result), 32'(e[W+1:2]));
        checkOutput("sb_carry_out", 32'(carry_out), 32'(e[1]));
        checkOutput("sb_overflow", 32'(overflow), 32'(e[0]));
        checkOutput("sb_busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    int base;
    reset  = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    a_in   = '0;
    b_in   = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_carry_out", 32'(carry_out), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    reset = 1'b0;

    $display("[TB] 3+2 add overflow");
    applyStimulus(3'd3, 3'd2, 1'b0, 1'b1, {3'b101, 1'b0, 1'b1});
    checkSequence("add32", 3'b011, 3'b010, 3'b100);
    waitIdle("add32");

    $display("[TB] 7+1 add wrap");
    applyStimulus(3'd7, 3'd1, 1'b0, 1'b1, {3'b000, 1'b1, 1'b0});
    checkSequence("add71", 3'b111, 3'b001, 3'b110);
    waitIdle("add71");

    $display("[TB] 2-3 subtract borrow");
    applyStimulus(3'd2, 3'd3, 1'b1, 1'b1, {3'b111, 1'b0, 1'b0});
    checkSequence("sub23", 3'b010, 3'b100, 3'b001);
    waitIdle("sub23");

    $display("[TB] 4-1 subtract overflow");
    applyStimulus(3'd4, 3'd1, 1'b1, 1'b1, {3'b011, 1'b1, 1'b1});
    checkSequence("sub41", 3'b100, 3'b110, 3'b001);
    waitIdle("sub41");

    $display("[TB] start ignored while busy");
    base = done_count;
    applyStimulus(3'd3, 3'd2, 1'b0, 1'b1, {3'b101, 1'b0, 1'b1});
    a_in  = 3'd0;
    b_in  = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle("busyprot");
    repeat (3) @(negedge clk);
    checkOutput("busyprot_done_count", 32'(done_count - base), 32'd1);
    checkOutput("busyprot_busy", 32'(busy), 32'd0);
    checkOutput("busyprot_result_held", 32'(result), 32'b101);

    $display("[TB] reset during second SHIFT cycle");
    base = done_count;
    applyStimulus(3'd3, 3'd2, 1'b0, 1'b0, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_result", 32'(result), 32'd0);
    checkOutput("midrst_carry_out", 32'(carry_out), 32'd0);
    checkOutput("midrst_overflow", 32'(overflow), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrst_no_done", 32'(done_count - base), 32'd0);
    applyStimulus(3'd1, 3'd1, 1'b0, 1'b1, {3'b010, 1'b0, 1'b0});
    checkSequence("add11", 3'b001, 3'b001, 3'b010);
    waitIdle("add11");

    $display("[TB] start held for back-to-back operations");
    base = done_count;
    @(negedge clk);
    a_in   = 3'd1;
    b_in   = 3'd2;
    op_sub = 1'b0;
    start  = 1'b1;
    exp_q.push_back({3'b011, 1'b0, 1'b0});
    exp_q.push_back({3'b011, 1'b0, 1'b0});
    for (int n = 0; n < 20 && done_count < base + 2; n++) @(negedge clk);
    start = 1'b0;
    waitIdle("b2b");
    repeat (2) @(negedge clk);
    checkOutput("b2b_done_count", 32'(done_count - base), 32'd2);
    checkOutput("b2b_spacing", 32'(last_done_cycle - prev_done_cycle), 32'(W + 2));

    checkOutput("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
